// File: rtl/sobel_gradient_pipe_if.sv
// Stream bundle for sobel_gradient_pipe: 3x3 window and threshold in,
// saturated gradient magnitude and edge flag out.
interface sobel_gradient_pipe_if #(
  parameter int NBIT = 8
) ();

  logic [NBIT-1:0] P0;
  logic [NBIT-1:0] P1;
  logic [NBIT-1:0] P2;
  logic [NBIT-1:0] P3;
  logic [NBIT-1:0] P4;
  logic [NBIT-1:0] P5;
  logic [NBIT-1:0] P6;
  logic [NBIT-1:0] P7;
  logic [NBIT-1:0] P8;
  logic [NBIT-1:0] T;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] mag;
  logic            edge_o;

  modport slave (
    input  P0, P1, P2, P3, P4,
    input  P5, P6, P7, P8, T,
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready,
    output mag,
    output edge_o
  );

  modport master (
    output P0, P1, P2, P3, P4,
    output P5, P6, P7, P8, T,
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  mag,
    input  edge_o
  );

endinterface

// File: rtl/sobel_gradient_pipe.sv
// 3-stage Sobel |Gx|+|Gy| pipeline with global stall and edge counter.
// Define SOBEL_DIAG_EN to also flag edges from the diagonal kernels.
module sobel_gradient_pipe #(
  parameter int NBIT = 8,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sobel_gradient_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      edge_cnt
);

  localparam int W = NBIT + 3;

  typedef logic [W-1:0]    wide_t;
  typedef logic [NBIT-1:0] pix_t;

  typedef struct packed {
    pix_t [8:0] p;
    pix_t       t;
  } s1_t;

  typedef struct packed {
    wide_t gx;
    wide_t gy;
`ifdef SOBEL_DIAG_EN
    wide_t d45;
    wide_t d135;
`endif
    pix_t  t;
  } s2_t;

  typedef struct packed {
    pix_t mag;
    logic edg;
  } s3_t;

  function automatic wide_t ext(input pix_t v);
    return {3'b000, v};
  endfunction

  // a + 2b + c, never wraps in W bits
  function automatic wide_t tap(
    input pix_t a,
    input pix_t b,
    input pix_t c
  );
    return ext(a) + (ext(b) << 1) + ext(c);
  endfunction

  function automatic wide_t absw(input wide_t g);
    return g[W-1] ? (~g) + wide_t'(1) : g;
  endfunction

  logic            adv;
  logic            s1_v_q;
  logic            s2_v_q;
  logic            s3_v_q;
  s1_t             s1_d;
  s1_t             s1_q;
  s2_t             s2_d;
  s2_t             s2_q;
  s3_t             s3_d;
  s3_t             s3_q;
  wide_t           sum;
`ifdef SOBEL_DIAG_EN
  wide_t           dsum;
`endif
  logic            xfer;
  logic [CNTW-1:0] cnt_d;
  logic [CNTW-1:0] cnt_q;

  // One stall for the whole pipe: only a held result blocks progress
  assign adv          = !s3_v_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    s1_d      = '0;
    s1_d.p[0] = bus.P0;
    s1_d.p[1] = bus.P1;
    s1_d.p[2] = bus.P2;
    s1_d.p[3] = bus.P3;
    s1_d.p[4] = bus.P4;
    s1_d.p[5] = bus.P5;
    s1_d.p[6] = bus.P6;
    s1_d.p[7] = bus.P7;
    s1_d.p[8] = bus.P8;
    s1_d.t    = bus.T;
  end

  always_comb begin
    s2_d    = '0;
    s2_d.gx = tap(s1_q.p[2], s1_q.p[5], s1_q.p[8])
            - tap(s1_q.p[0], s1_q.p[3], s1_q.p[6]);
    s2_d.gy = tap(s1_q.p[6], s1_q.p[7], s1_q.p[8])
            - tap(s1_q.p[0], s1_q.p[1], s1_q.p[2]);
`ifdef SOBEL_DIAG_EN
    s2_d.d45  = tap(s1_q.p[1], s1_q.p[2], s1_q.p[5])
              - tap(s1_q.p[3], s1_q.p[6], s1_q.p[7]);
    s2_d.d135 = tap(s1_q.p[5], s1_q.p[8], s1_q.p[7])
              - tap(s1_q.p[1], s1_q.p[0], s1_q.p[3]);
`endif
    s2_d.t  = s1_q.t;
  end

  always_comb begin
    s3_d     = '0;
    sum      = absw(s2_q.gx) + absw(s2_q.gy);
    s3_d.mag = (|sum[W-1:NBIT]) ? {NBIT{1'b1}}
                                : sum[NBIT-1:0];
    s3_d.edg = sum >= ext(s2_q.t);
`ifdef SOBEL_DIAG_EN
    dsum     = absw(s2_q.d45) + absw(s2_q.d135);
    s3_d.edg = s3_d.edg || (dsum >= ext(s2_q.t));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
    end else if (adv) begin
      s1_v_q <= bus.in_valid;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
    end
  end

  assign bus.out_valid = s3_v_q;
  assign bus.mag       = s3_q.mag;
  assign bus.edge_o    = s3_q.edg;

  assign xfer = s3_v_q && bus.out_ready && s3_q.edg;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Scoreboard bench for sobel_gradient_pipe: directed windows, stall,
// mid-stream reset and a narrow-counter instance for saturation/clear.
module tb_sobel_gradient_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic        cnt_clr2;
  logic [15:0] edge_cnt;
  logic [1:0]  edge_cnt2;

  always #5 clk = ~clk;

  sobel_gradient_pipe_if #(.NBIT(8)) bus  ();
  sobel_gradient_pipe_if #(.NBIT(8)) bus2 ();

  sobel_gradient_pipe #(.NBIT(8), .CNTW(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .edge_cnt (edge_cnt)
  );

  sobel_gradient_pipe #(.NBIT(8), .CNTW(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus2),
    .cnt_clr  (cnt_clr2),
    .edge_cnt (edge_cnt2)
  );

  // Hand-computed vectors: P0..P8, T, mag, edge, edge with diagonals
  int vp [0:10][0:8] = '{
    '{100,100,100,100,100,100,100,100,100},
    '{0,0,255,0,0,255,0,0,255},
    '{0,0,10,0,0,0,0,0,0},
    '{0,0,10,0,0,0,0,0,0},
    '{0,0,20,10,0,0,0,10,0},
    '{0,0,0,0,0,0,0,0,0},
    '{0,0,0,0,0,0,0,50,0},
    '{0,30,0,0,0,0,0,0,0},
    '{0,0,0,0,0,0,0,0,255},
    '{0,0,0,0,0,0,0,0,127},
    '{0,0,0,0,0,0,0,0,128}
  };
  int vt   [0:10] = '{1, 255, 20, 21, 10, 0, 100, 61, 255, 255, 255};
  int vmag [0:10] = '{0, 255, 20, 20, 0, 0, 100, 60, 255, 254, 255};
  int vedg [0:10] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};
  int vedd [0:10] = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1};

  typedef struct {
    int mag;
    int edg;
  } exp_t;

  exp_t expq[$];
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;
  int   cyc     = 0;
  int   c0;
  int   n;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_edge(input int i);
`ifdef SOBEL_DIAG_EN
    return vedd[i];
`else
    return vedg[i];
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    bus.P0 = 8'(vp[i][0]);
    bus.P1 = 8'(vp[i][1]);
    bus.P2 = 8'(vp[i][2]);
    bus.P3 = 8'(vp[i][3]);
    bus.P4 = 8'(vp[i][4]);
    bus.P5 = 8'(vp[i][5]);
    bus.P6 = 8'(vp[i][6]);
    bus.P7 = 8'(vp[i][7]);
    bus.P8 = 8'(vp[i][8]);
    bus.T  = 8'(vt[i]);
  endtask

  task automatic drive2(input int i);
    bus2.P0 = 8'(vp[i][0]);
    bus2.P1 = 8'(vp[i][1]);
    bus2.P2 = 8'(vp[i][2]);
    bus2.P3 = 8'(vp[i][3]);
    bus2.P4 = 8'(vp[i][4]);
    bus2.P5 = 8'(vp[i][5]);
    bus2.P6 = 8'(vp[i][6]);
    bus2.P7 = 8'(vp[i][7]);
    bus2.P8 = 8'(vp[i][8]);
    bus2.T  = 8'(vt[i]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input int i);
    exp_t e;
    drive(i);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.mag = vmag[i];
        e.edg = exp_edge(i);
        expq.push_back(e);
        step();
        bus.in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: vector %0d never accepted", i);
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic send2(input int i);
    drive2(i);
    bus2.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus2.in_ready) begin
        step();
        bus2.in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send2_timeout: vector %0d never accepted", i);
    bus2.in_valid = 1'b0;
    step();
  endtask

  // Counts negedges until out_valid; -1 when the bound expires
  task automatic wait_out(input bit second, output int cnt);
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (second ? bus2.out_valid : bus.out_valid) begin
        cnt = k;
        return;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 80; k++) begin
      if (expq.size() == 0) break;
      step();
    end
    chk("drain_left", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got mag=%0d edge=%0d want none",
                 bus.mag, bus.edge_o);
      end else begin
        if (int'(bus.mag) != expq[0].mag
            || int'(bus.edge_o) != expq[0].edg) begin
          bad++;
          $display("FAIL result: got mag=%0d edge=%0d want mag=%0d edge=%0d",
                   bus.mag, bus.edge_o, expq[0].mag, expq[0].edg);
        end
        if (bus.out_ready) begin
          if (expq[0].edg != 0) exp_cnt++;
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    cnt_clr        = 1'b0;
    cnt_clr2       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
    drive(0);
    drive2(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.mag), 0);
    chk("rst_edge", int'(bus.edge_o), 0);
    chk("rst_edge_cnt", int'(edge_cnt), 0);
    chk("rst_edge_cnt2", int'(edge_cnt2), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", int'(bus.in_ready), 1);
    step();

    send(0);
    wait_out(1'b0, n);
    chk("latency", n, 3);
    step();
    drain();
    chk("cnt_flat", int'(edge_cnt), 0);

    send(2);
    send(3);
    send(4);
    send(1);
    drain();
    chk("cnt_singles", int'(edge_cnt), exp_cnt);

    fork
      begin
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(i);
        chk("throughput_cycles", cyc - c0, 4);
        for (int i = 4; i < 11; i++) begin
          send(i);
          if (i == 6) step();
        end
      end
      begin
        repeat (6) step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", int'(bus.in_ready), 0);
        chk("stall_out_valid", int'(bus.out_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_stream", int'(edge_cnt), exp_cnt);

    send(1);
    wait_out(1'b0, n);
    chk("clr_out_seen", n, 3);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("cnt_clr_wins", int'(edge_cnt), 0);
    step();

    send(1);
    send(2);
    rst = 1'b1;
    expq.delete();
    step();
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_edge_cnt", int'(edge_cnt), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_stale_result", int'(bus.out_valid), 0);
    end
    step();
    send(5);
    drain();
    chk("cnt_after_rst", int'(edge_cnt), 1);

    for (int i = 0; i < 3; i++) send2(1);
    repeat (6) step();
    chk("cnt2_three", int'(edge_cnt2), 3);
    send2(1);
    send2(1);
    repeat (6) step();
    chk("cnt2_saturated", int'(edge_cnt2), 3);
    send2(1);
    wait_out(1'b1, n);
    chk("cnt2_out_seen", n, 3);
    cnt_clr2 = 1'b1;
    step();
    cnt_clr2 = 1'b0;
    @(negedge clk);
    chk("cnt2_clr_wins", int'(edge_cnt2), 0);
    step();
    send2(2);
    repeat (6) step();
    chk("cnt2_after_clr", int'(edge_cnt2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_gradient_pipe.md
SOBEL_GRADIENT_PIPE -- requirements
Module: sobel_gradient_pipe

Interface
REQ-001 The block SHALL have parameter NBIT, default 8, meaning the pixel and threshold width in bits (legal range 4..16).
REQ-002 The block SHALL have parameter CNTW, default 16, meaning the edge-counter width.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Ports P0..P8  input  NBIT each  3x3 window, row-major, P4 = centre, unsigned.
REQ-006 Port T  input  NBIT  edge threshold, unsigned, captured together with the window.
REQ-007 Port in_valid  input  1  window and T are valid.
REQ-008 Port in_ready  output  1  the block accepts the window this cycle.
REQ-009 Port out_valid  output  1  mag and edge are valid.
REQ-010 Port out_ready  input  1  the consumer accepts the result this cycle.
REQ-011 Port mag  output  NBIT  |Gx|+|Gy|, saturated to 2^NBIT-1.
REQ-012 Port edge  output  1  1 when the unsaturated magnitude is >= T.
REQ-013 Port cnt_clr  input  1  synchronous clear of edge_cnt.
REQ-014 Port edge_cnt  output  CNTW  saturating count of transferred results with edge=1.

Function
REQ-015 Gx SHALL be (P2+2P5+P8)-(P0+2P3+P6), and Gy SHALL be (P6+2P7+P8)-(P0+2P1+P2), both signed NBIT+3 bits with no overflow.
REQ-016 The sum S = |Gx|+|Gy| SHALL be unsigned NBIT+3 bits; mag SHALL be min(S, 2^NBIT-1).
REQ-017 edge SHALL be (S >= zero-extended T); T=0 gives edge=1.
REQ-018 The pipeline SHALL have 3 register stages (S1 capture window/T, S2 Gx/Gy, S3 mag/edge), each with its own valid bit.
REQ-019 A transfer SHALL occur on a cycle where valid and ready are both 1; a window accepted in cycle n SHALL appear at the outputs in cycle n+3 when out_ready is held at 1.
REQ-020 The stall SHALL be global: in_ready = !S3_valid || out_ready; when in_ready=0, every stage SHALL hold its contents.
REQ-021 While out_valid=1 and out_ready=0, mag, edge and out_valid SHALL stay stable.
REQ-022 Bubbles SHALL propagate; sustained throughput SHALL be 1 result per cycle with no stall.
REQ-023 edge_cnt SHALL increment by 1 on each output transfer with edge=1 and saturate at 2^CNTW-1.
REQ-024 If cnt_clr and a counting transfer occur in the same cycle, cnt_clr SHALL win and edge_cnt SHALL become 0.

Reset
REQ-025 On rst: all stage valids, out_valid, mag, edge and edge_cnt SHALL be 0; in_ready SHALL be 1 in the first cycle after reset.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight windows, and no result of those windows SHALL appear after reset.
REQ-027 rst SHALL take priority over cnt_clr and over every transfer.

Configuration
REQ-028 Macro SOBEL_DIAG_EN: when defined, S2 SHALL also compute D45=(P1+2P2+P5)-(P3+2P6+P7) and D135=(P5+2P8+P7)-(P1+2P0+P3), and edge SHALL be (S>=T) OR (|D45|+|D135|>=T).
REQ-029 mag SHALL be unaffected by SOBEL_DIAG_EN.
REQ-030 Without SOBEL_DIAG_EN, the diagonal logic SHALL be absent and edge SHALL follow REQ-017 only; latency SHALL be 3 in both builds.

Verification
REQ-031 NBIT=8, all P=100, T=1, out_ready=1 -> 3 cycles later out_valid=1, mag=0, edge=0, edge_cnt unchanged.
REQ-032 P0=P3=P6=0, P2=P5=P8=255, others 0, T=255 -> S=1020, mag=255, edge=1, edge_cnt +1.
REQ-033 P2=10, others 0 -> mag=20; with T=20, edge=1; with T=21, edge=0.
REQ-034 P2=20, P3=10, P7=10, others 0, T=10 -> mag=0; edge=0 without SOBEL_DIAG_EN; edge=1 with it.
REQ-035 Stream 8 windows with out_ready low for 5 cycles mid-stream -> in_ready falls, outputs stay stable, and all 8 results arrive in order with none lost or duplicated; then assert rst with 2 windows in flight -> out_valid=0 next cycle and no stale result appears.
REQ-036 CNTW=2: 5 edge results -> edge_cnt saturates at 3; cnt_clr asserted during an edge transfer -> edge_cnt=0.
